// File: rtl/vasm_pkg.sv
// vasm_pkg: VASM opcode encoding shared by the decoder, the trace unit and the opcode encoder.
package vasm_pkg;
    localparam int INSTR_W     = 32;
    localparam int NUM_OPCODES = 20;

    typedef enum logic [4:0] {
        NOP   = 5'd0,
        JXX   = 5'd1,
        ADD   = 5'd2,
        SUB   = 5'd3,
        CMP   = 5'd4,
        AND   = 5'd5,
        OR    = 5'd6,
        XOR   = 5'd7,
        NOT   = 5'd8,
        NEG   = 5'd9,
        SHL   = 5'd10,
        SHR   = 5'd11,
        ST    = 5'd12,
        LD    = 5'd13,
        MOV   = 5'd14,
        HLT   = 5'd15,
        LDUMP = 5'd16,
        SDUMP = 5'd17,
        FREE  = 5'd18,
        SPAWN = 5'd19
    } opcode_t;
endpackage

// File: rtl/onehot_enc.sv
// onehot_enc: one-hot instruction strobe vector to VASM opcode; anything not exactly
// one bit within NOP..SPAWN is reported illegal and encoded as NOP.
module onehot_enc
    import vasm_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output opcode_t            opcode,
    output logic               illegal
);
    always_comb begin
        opcode  = NOP;
        illegal = 1'b1;
        for (int i = 0; i < NUM_OPCODES; i++) begin
            if (instr == (INSTR_W'(1) << i)) begin
                opcode  = opcode_t'(5'(i));
                illegal = 1'b0;
            end
        end
    end
endmodule

// File: rtl/opcode_encoder.sv
// opcode_encoder: encodes one-hot instruction strobes into VASM opcodes, queued in a
// small FIFO with valid/ready on both sides and a saturating malformed-word counter.
module opcode_encoder
    import vasm_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ERR_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         opcode,
    output logic               out_illegal,
    output logic [ERR_W-1:0]   err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    opcode_t         enc_op;
    logic            enc_ill;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    opcode_t         mem_op [DEPTH];
    logic            mem_ill [DEPTH];
    logic            accept, push, pop;

    onehot_enc u_enc (
        .instr   (instr),
        .opcode  (enc_op),
        .illegal (enc_ill)
    );

    assign in_ready    = count != FULL;
    assign out_valid   = count != '0;
    assign accept      = in_valid && in_ready;
    assign push        = accept && !flush;
    assign pop         = out_valid && out_ready && !flush;
    assign opcode      = out_valid ? mem_op[rd_ptr] : 5'd0;
    assign out_illegal = out_valid && mem_ill[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // illegal words accepted during a flush cycle still count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt <= '0;
        else if (accept && enc_ill && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_op[wr_ptr]  <= enc_op;
            mem_ill[wr_ptr] <= enc_ill;
        end
    end
endmodule

// File: tb/tb_opcode_encoder.sv
// tb_opcode_encoder: directed and random stimulus against a queue-based reference model.
module tb_opcode_encoder;
    localparam int DEPTH = 4;
    localparam int ERR_W = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [4:0]  opcode;
    logic        out_illegal;
    logic [ERR_W-1:0] err_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] q[$];
    int m_err = 0;

    opcode_encoder #(.DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode      (opcode),
        .out_illegal (out_illegal),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {illegal, opcode}: legal iff a single set bit at index 0..19
    function automatic logic [5:0] ref_enc(input logic [31:0] w);
        if ($countones(w) == 1 && w < 32'h0010_0000) return {1'b0, 5'($clog2(w))};
        return 6'b10_0000;
    endfunction

    task automatic check_all();
        check("out_valid", out_valid, q.size() > 0);
        check("opcode", opcode, q.size() > 0 ? q[0][4:0] : 5'd0);
        check("out_illegal", out_illegal, q.size() > 0 ? q[0][5] : 1'b0);
        check("in_ready", in_ready, q.size() < DEPTH);
        check("err_cnt", err_cnt, m_err);
    endtask

    task automatic step(input logic v, input logic [31:0] w, input logic r, input logic f);
        logic [5:0] e;
        bit acc, pop;
        in_valid = v; instr = w; out_ready = r; flush = f;
        e = ref_enc(w);
        acc = v && q.size() < DEPTH;
        pop = q.size() > 0 && r;
        @(posedge clk); #1;
        if (acc && e[5] && m_err < 255) m_err++;
        if (f) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_all();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check("rst opcode", opcode, 0);
        check("rst in_ready", in_ready, 1);
        rst_n = 1'b1;

        step(1, 32'h0000_0004, 1, 0);
        check("add opcode", opcode, 5'd2);
        step(0, 0, 1, 0);
        check("add drained", out_valid, 0);

        step(1, 32'h0008_0000, 1, 0);
        check("spawn opcode", opcode, 5'd19);
        step(1, 32'h0010_0000, 1, 0);
        step(1, 32'h0000_0006, 1, 0);
        step(1, 32'h0000_0000, 1, 0);
        step(0, 0, 1, 0);
        check("err after 3", err_cnt, 3);

        for (int i = 12; i < 16; i++) step(1, 32'h1 << i, 0, 0);
        check("full in_ready", in_ready, 0);
        step(1, 32'h2, 0, 0);
        check("held off head", opcode, 5'd12);
        step(0, 0, 1, 0);
        check("in_ready after pop", in_ready, 1);
        check("second head", opcode, 5'd13);
        repeat (4) step(0, 0, 1, 0);

        step(1, 32'h1 << 5, 0, 0);
        step(1, 32'h1 << 6, 0, 0);
        step(1, 32'h1 << 7, 1, 0);
        check("pushpop head", opcode, 5'd6);
        repeat (3) step(0, 0, 1, 0);

        for (int i = 1; i < 4; i++) step(1, 32'h1 << i, 0, 0);
        step(1, 32'h3, 0, 1);
        check("flush empty", out_valid, 0);
        check("flush err", err_cnt, 4);

        for (int i = 0; i < 300; i++) step(1, 32'hFFFF_0000, 1, 0);
        check("err sat", err_cnt, 255);

        for (int i = 0; i < 2000; i++) begin
            logic [31:0] w;
            case ($urandom_range(0, 3))
                0, 1: w = 32'h1 << $urandom_range(0, 31);
                2: w = 32'h0;
                default: w = $urandom;
            endcase
            step($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0, $urandom_range(0, 40) == 0);
        end

        rst_n = 1'b0;
        #1;
        q.delete(); m_err = 0;
        check_all();
        rst_n = 1'b1;
        step(1, 32'h1 << 9, 0, 0);
        step(1, 32'h1 << 10, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        q.delete(); m_err = 0;
        check_all();
        check("async rst empty", out_valid, 0);
        rst_n = 1'b1;
        step(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
